// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable controller.
//   gate_state_t : FSM state encoding (2 bits)
//   *_DEF        : default timing and statistics widths used by clk_gate_ctrl
package clk_gate_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } gate_state_t;

   localparam int WAKE_CYC_DEF = 2;
   localparam int IDLE_CYC_DEF = 8;
   localparam int CNT_W_DEF    = 4;
   localparam int STAT_W_DEF   = 16;

endpackage

// File: rtl/gate_stat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk : counting clock
//   rst : asynchronous active-high reset, clears the count
//   clr : synchronous clear, wins over inc
//   inc : count this cycle
//   cnt : current count, holds at all-ones instead of wrapping
module gate_stat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller feeding a latch-based clock-gating cell.
// Turns clock requests, gated-domain activity and a debug override into a
// registered CLK_EN, with a settle window before ACK and an idle hysteresis
// window before the clock is shut off. Also counts enabled cycles.
//   CLK      : ungated reference clock (same clock as the gate cell)
//   RST      : asynchronous active-high reset
//   REQ      : functional clock request (level)
//   BUSY     : gated domain still active; keeps the clock on, never wakes it
//   FORCE_ON : override, keeps the clock enabled while high
//   CNT_CLR  : synchronous clear of ON_CNT
//   CLK_EN   : registered enable to the gate cell
//   ACK      : registered, gated clock running and settled
//   ON_CNT   : saturating count of cycles with CLK_EN=1
// CNT_W must satisfy 2**CNT_W > max(WAKE_CYC, IDLE_CYC).
//
// state | meaning
// ------+--------------------------------------------------------------
// OFF   | clock gated off, CLK_EN=0 ACK=0
// WAKE  | clock running, settling for WAKE_CYC cycles, ACK=0
// ON    | clock running and acknowledged
// HOLD  | no activity, counting down IDLE_CYC before turning off
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int WAKE_CYC = WAKE_CYC_DEF,
   parameter int IDLE_CYC = IDLE_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int STAT_W   = STAT_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic              BUSY,
   input  logic              FORCE_ON,
   input  logic              CNT_CLR,
   output logic              CLK_EN,
   output logic              ACK,
   output logic [STAT_W-1:0] ON_CNT
);

   // Down-counter load values; a zero-length window never loads the counter.
   localparam logic [CNT_W-1:0] WAKE_LD = (WAKE_CYC > 0) ? CNT_W'(WAKE_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] IDLE_LD = (IDLE_CYC > 0) ? CNT_W'(IDLE_CYC - 1) : '0;

   gate_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             want;
   logic             wake_req;

   // BUSY only sustains the clock; it cannot start it from OFF.
   assign want     = REQ | BUSY | FORCE_ON;
   assign wake_req = REQ | FORCE_ON;

   // CLK_EN/ACK are written alongside the next state so both are plain flop
   // outputs; the gate latch is transparent while CLK is low and must never
   // see a combinational glitch.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ST_OFF;
         cnt    <= '0;
         CLK_EN <= 1'b0;
         ACK    <= 1'b0;
      end else begin
         case (state)
            ST_OFF: begin
               if (wake_req) begin
                  CLK_EN <= 1'b1;
                  if (WAKE_CYC > 0) begin
                     state <= ST_WAKE;
                     cnt   <= WAKE_LD;
                     ACK   <= 1'b0;
                  end else begin
                     state <= ST_ON;
                     ACK   <= 1'b1;
                  end
               end
            end
            // WAKE always completes, even if the request goes away.
            ST_WAKE: begin
               if (cnt == '0) begin
                  state <= ST_ON;
                  ACK   <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_ON: begin
               if (!want) begin
                  if (IDLE_CYC > 0) begin
                     state <= ST_HOLD;
                     cnt   <= IDLE_LD;
                  end else begin
                     state  <= ST_OFF;
                     CLK_EN <= 1'b0;
                     ACK    <= 1'b0;
                  end
               end
            end
            // Renewed activity returns to ON without a wake penalty.
            ST_HOLD: begin
               if (want) begin
                  state <= ST_ON;
               end else if (cnt == '0) begin
                  state  <= ST_OFF;
                  CLK_EN <= 1'b0;
                  ACK    <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state  <= ST_OFF;
               CLK_EN <= 1'b0;
               ACK    <= 1'b0;
            end
         endcase
      end
   end

   gate_stat_cnt #(
      .W (STAT_W)
   ) u_stat (
      .clk (CLK),
      .rst (RST),
      .clr (CNT_CLR),
      .inc (CLK_EN),
      .cnt (ON_CNT)
   );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl.
// u_dut0 : WAKE_CYC=2, IDLE_CYC=8, STAT_W=16
// u_dut1 : WAKE_CYC=0, IDLE_CYC=0 corner build
module tb_clk_gate_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, busy0, fon0, clr0;
   logic        req1, busy1, fon1, clr1;
   logic        en0, ack0, en1, ack1;
   logic [15:0] cnt0, cnt1;

   clk_gate_ctrl #(.WAKE_CYC(2), .IDLE_CYC(8), .CNT_W(4), .STAT_W(16)) u_dut0 (
      .CLK(clk), .RST(rst), .REQ(req0), .BUSY(busy0), .FORCE_ON(fon0),
      .CNT_CLR(clr0), .CLK_EN(en0), .ACK(ack0), .ON_CNT(cnt0));

   clk_gate_ctrl #(.WAKE_CYC(0), .IDLE_CYC(0), .CNT_W(2), .STAT_W(16)) u_dut1 (
      .CLK(clk), .RST(rst), .REQ(req1), .BUSY(busy1), .FORCE_ON(fon1),
      .CNT_CLR(clr1), .CLK_EN(en1), .ACK(ack1), .ON_CNT(cnt1));

   typedef struct {
      string       tag;
      int          sel;
      logic        en;
      logic        ack;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [15:0] m_cnt [2];
   logic        m_en  [2];

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are already driven; expected post-edge outputs are queued, one
   // clock edge passes, then the entry is popped and compared.
   task automatic step(input int sel, input string tag, input logic e_en, input logic e_ack);
      exp_t e;
      logic clr;
      clr = (sel == 0) ? clr0 : clr1;
      if (clr)
         m_cnt[sel] = 16'd0;
      else if (m_en[sel] && (m_cnt[sel] != 16'hffff))
         m_cnt[sel] = m_cnt[sel] + 16'd1;
      m_en[sel] = e_en;
      sb.push_back('{tag, sel, e_en, e_ack, m_cnt[sel]});
      @(negedge clk);
      e = sb.pop_front();
      if (e.sel == 0) begin
         cmp({e.tag, ".en"},  32'(en0),  32'(e.en));
         cmp({e.tag, ".ack"}, 32'(ack0), 32'(e.ack));
         cmp({e.tag, ".cnt"}, 32'(cnt0), 32'(e.cnt));
      end else begin
         cmp({e.tag, ".en"},  32'(en1),  32'(e.en));
         cmp({e.tag, ".ack"}, 32'(ack1), 32'(e.ack));
         cmp({e.tag, ".cnt"}, 32'(cnt1), 32'(e.cnt));
      end
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; busy0 = 1'b0; fon0 = 1'b0; clr0 = 1'b0;
      req1 = 1'b0; busy1 = 1'b0; fon1 = 1'b0; clr1 = 1'b0;
      m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
      m_en[0]  = 1'b0;  m_en[1]  = 1'b0;
      repeat (2) @(negedge clk);
      cmp("rst.en0",  32'(en0),  32'd0);
      cmp("rst.ack0", 32'(ack0), 32'd0);
      cmp("rst.cnt0", 32'(cnt0), 32'd0);
      cmp("rst.en1",  32'(en1),  32'd0);
      cmp("rst.ack1", 32'(ack1), 32'd0);
      cmp("rst.cnt1", 32'(cnt1), 32'd0);
      rst = 1'b0;

      // Wake with WAKE_CYC=2, then run ON
      repeat (4) step(0, "a.idle", 1'b0, 1'b0);
      req0 = 1'b1;
      step(0, "a.wake0", 1'b1, 1'b0);
      step(0, "a.wake1", 1'b1, 1'b0);
      step(0, "a.ack",   1'b1, 1'b1);
      repeat (10) step(0, "a.on", 1'b1, 1'b1);

      // Idle out after IDLE_CYC=8, ON_CNT frozen afterwards
      req0 = 1'b0;
      repeat (8) step(0, "b.hold", 1'b1, 1'b1);
      step(0, "b.off", 1'b0, 1'b0);
      repeat (3) step(0, "b.frozen", 1'b0, 1'b0);

      // BUSY returns during HOLD: clock never drops
      req0 = 1'b1;
      step(0, "c.wake0", 1'b1, 1'b0);
      step(0, "c.wake1", 1'b1, 1'b0);
      step(0, "c.ack",   1'b1, 1'b1);
      repeat (3) step(0, "c.on", 1'b1, 1'b1);
      req0 = 1'b0;
      repeat (3) step(0, "c.hold", 1'b1, 1'b1);
      busy0 = 1'b1;
      repeat (10) step(0, "c.busy", 1'b1, 1'b1);
      busy0 = 1'b0;
      repeat (8) step(0, "c.hold2", 1'b1, 1'b1);
      step(0, "c.off", 1'b0, 1'b0);

      // REQ dropped inside WAKE: still acks, then HOLD, then off
      req0 = 1'b1;
      step(0, "d.wake0", 1'b1, 1'b0);
      req0 = 1'b0;
      step(0, "d.wake1", 1'b1, 1'b0);
      step(0, "d.ack",   1'b1, 1'b1);
      repeat (8) step(0, "d.hold", 1'b1, 1'b1);
      step(0, "d.off", 1'b0, 1'b0);

      // Asynchronous reset in HOLD
      req0 = 1'b1;
      step(0, "e.wake0", 1'b1, 1'b0);
      step(0, "e.wake1", 1'b1, 1'b0);
      step(0, "e.ack",   1'b1, 1'b1);
      req0 = 1'b0;
      repeat (2) step(0, "e.hold", 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      cmp("e.arst.en",  32'(en0),  32'd0);
      cmp("e.arst.ack", 32'(ack0), 32'd0);
      cmp("e.arst.cnt", 32'(cnt0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
      m_en[0]  = 1'b0;  m_en[1]  = 1'b0;
      repeat (2) step(0, "e.off", 1'b0, 1'b0);
      busy0 = 1'b1;
      repeat (3) step(0, "e.busy_only", 1'b0, 1'b0);
      busy0 = 1'b0;

      // FORCE_ON long enough to saturate, then clear against an increment
      fon0 = 1'b1;
      step(0, "g.wake0", 1'b1, 1'b0);
      step(0, "g.wake1", 1'b1, 1'b0);
      step(0, "g.ack",   1'b1, 1'b1);
      repeat (70000) step(0, "g.force", 1'b1, 1'b1);
      cmp("g.sat", 32'(cnt0), 32'h0000ffff);
      clr0 = 1'b1;
      step(0, "g.clr", 1'b1, 1'b1);
      clr0 = 1'b0;
      step(0, "g.recount", 1'b1, 1'b1);
      fon0 = 1'b0;
      repeat (8) step(0, "g.hold", 1'b1, 1'b1);
      step(0, "g.off", 1'b0, 1'b0);

      // Corner build: WAKE_CYC=0, IDLE_CYC=0
      req1 = 1'b1;
      step(1, "h.on0", 1'b1, 1'b1);
      repeat (2) step(1, "h.on", 1'b1, 1'b1);
      req1 = 1'b0;
      step(1, "h.off", 1'b0, 1'b0);
      busy1 = 1'b1;
      step(1, "h.busy_only", 1'b0, 1'b0);
      busy1 = 1'b0;
      fon1 = 1'b1;
      step(1, "h.force", 1'b1, 1'b1);
      fon1 = 1'b0;
      step(1, "h.force_off", 1'b0, 1'b0);
      req1 = 1'b1;
      step(1, "h.req", 1'b1, 1'b1);
      busy1 = 1'b1;
      req1  = 1'b0;
      repeat (2) step(1, "h.busy", 1'b1, 1'b1);
      busy1 = 1'b0;
      step(1, "h.off2", 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Enable controller sitting directly upstream of the clock-gating cell. It converts functional clock requests from the system controller (REQ), activity reporting from the gated domain (BUSY) and a debug/scan override (FORCE_ON) into a glitch-safe, registered CLK_EN for the gate. It adds a wake-up settle window before acknowledging and an idle hysteresis window before shutting the clock off. It also keeps a saturating count of enabled cycles for power profiling.

## Interface
- WAKE_CYC, 2: cycles between CLK_EN rising and ACK rising; 0 allowed.
- IDLE_CYC, 8: idle cycles in HOLD before CLK_EN falls; 0 allowed.
- CNT_W, 4: hold/wake counter width; must satisfy 2^CNT_W > max(WAKE_CYC, IDLE_CYC).
- STAT_W, 16: enabled-cycle statistics counter width.

Ports:
- CLK  in  1  ungated reference clock, same clock that feeds the gate cell.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  1  functional request for the gated clock; level.
- BUSY  in  1  gated domain still active; level, synchronous to CLK.
- FORCE_ON  in  1  override; keeps the clock enabled while high.
- CNT_CLR  in  1  synchronous clear of ON_CNT.
- CLK_EN  out  1  registered enable to the gate cell.
- ACK  out  1  registered; gated clock is running and settled.
- ON_CNT  out  STAT_W  saturating count of cycles with CLK_EN=1.

## Operation
- Reset values: state OFF, CLK_EN=0, ACK=0, internal counter=0, ON_CNT=0.
- Define want = REQ | BUSY | FORCE_ON. BUSY alone never wakes the clock from OFF; only REQ or FORCE_ON do.
- OFF: CLK_EN=0, ACK=0.
  - REQ|FORCE_ON with WAKE_CYC>0 -> WAKE, counter := WAKE_CYC-1.
  - REQ|FORCE_ON with WAKE_CYC=0 -> ON.
- WAKE: CLK_EN=1, ACK=0. The counter decrements each cycle; at counter=0 -> ON. WAKE never aborts: a REQ drop inside WAKE still completes to ON, and ON then exits through HOLD.
- ON: CLK_EN=1, ACK=1.
  - !want with IDLE_CYC>0 -> HOLD, counter := IDLE_CYC-1.
  - !want with IDLE_CYC=0 -> OFF.
- HOLD: CLK_EN=1, ACK=1.
  - want -> ON, with no wake penalty.
  - Otherwise the counter decrements; at counter=0 -> OFF.
- CLK_EN and ACK are decoded from the next state and registered, so both are glitch-free flop outputs. This is required because the downstream latch is transparent while CLK is low.
- ON_CNT increments on every cycle where CLK_EN=1 and saturates at 2^STAT_W-1 (no wrap). CNT_CLR has priority over increment.
- Scan enable is not handled here; the gate cell ORs its own test enable.

## Timing
- REQ sampled high at edge k from OFF:
  - CLK_EN=1 from edge k.
  - ACK=1 from edge k+WAKE_CYC. With WAKE_CYC=0, both rise at edge k.
- want sampled low at edge j in ON: CLK_EN and ACK fall at edge j+IDLE_CYC.
- want returning during HOLD: the state is ON at the next edge, and CLK_EN/ACK stay high continuously.
- Asynchronous RST mid-operation forces CLK_EN=0 immediately. The downstream latch is required to absorb this; this is a documented integration rule.
- CNT_CLR and saturation take effect at the next edge.

## Structure
- Package clk_gate_pkg holds:
  - the state enum (OFF, WAKE, ON, HOLD) in 2-bit encoding;
  - the default WAKE_CYC, IDLE_CYC and STAT_W constants.
- Sub-module gate_stat_cnt: the parameterised saturating counter with clear and increment inputs, instantiated for ON_CNT.
- The FSM and the hold/wake counter stay in the top module.

## Test plan
- Reset release, then REQ pulse at edge 5 (WAKE_CYC=2) -> CLK_EN=1 after edge 5, ACK=1 after edge 7, ON_CNT counting from 1.
- REQ drops at edge 20, BUSY=0 (IDLE_CYC=8) -> CLK_EN and ACK low after edge 28; ON_CNT frozen.
- REQ drops, then BUSY rises 3 cycles into HOLD -> state ON, CLK_EN never drops; after BUSY falls, CLK_EN falls 8 cycles later.
- REQ dropped during WAKE -> ACK still rises at wake end; the FSM enters HOLD and turns off IDLE_CYC cycles later.
- FORCE_ON held for 70000 cycles with STAT_W=16 -> ON_CNT saturates at 65535. CNT_CLR coincident with an increment -> ON_CNT=0.
- RST asserted mid-HOLD -> CLK_EN=0 and ACK=0 asynchronously; after release the FSM is in OFF. Also run WAKE_CYC=0 and IDLE_CYC=0 corner builds.
